// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FIFO controller sequencing an external dual-port RAM behind a 2-entry show-ahead buffer
module ram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [ADDR_WIDTH+1:0] count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] MEM_FULL = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   mem_cnt;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] buf_head;
  logic [DATA_WIDTH-1:0] buf_skid;
  logic [1:0]            buf_cnt;

  logic       push;
  logic       pop;
  logic       fetch;
  logic [2:0] occ_after_pop;
  logic [1:0] land_idx;

  // Handshakes and the fetch decision; in_ready looks only at registered state
  always_comb begin
    in_ready      = (mem_cnt != MEM_FULL);
    out_valid     = (buf_cnt != 2'd0);
    out_data      = buf_head;
    push          = in_valid & in_ready;
    pop           = out_valid & out_ready;
    // Buffer slots already claimed once this cycle's pop is taken into account
    occ_after_pop = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    // mem_cnt counts committed words only, so a word pushed this cycle is never fetched this cycle
    fetch         = (mem_cnt != '0) && (occ_after_pop < 3'd2);
    // Landing slot is the first free entry after the head has shifted on pop
    land_idx      = buf_cnt - {1'b0, pop};
    ram_we        = push;
    ram_waddr     = wptr;
    ram_din       = in_data;
    ram_raddr     = rptr;
    count         = (ADDR_WIDTH + 2)'(mem_cnt) + (ADDR_WIDTH + 2)'(inflight)
                  + (ADDR_WIDTH + 2)'(buf_cnt);
  end

  // Pointer, RAM occupancy and outstanding-fetch tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + ADDR_WIDTH'(1);
      end
      if (fetch) begin
        rptr <= rptr + ADDR_WIDTH'(1);
      end
      case ({push, fetch})
        2'b10:   mem_cnt <= mem_cnt + (ADDR_WIDTH + 1)'(1);
        2'b01:   mem_cnt <= mem_cnt - (ADDR_WIDTH + 1)'(1);
        default: mem_cnt <= mem_cnt;
      endcase
      inflight <= fetch;
    end
  end

  // Show-ahead buffer: shift skid to head on pop, then land the RAM word in the first free slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_head <= '0;
      buf_skid <= '0;
      buf_cnt  <= 2'd0;
    end else begin
      if (inflight && (land_idx == 2'd0)) begin
        buf_head <= ram_dout;
      end else if (pop) begin
        buf_head <= buf_skid;
      end
      if (inflight && (land_idx == 2'd1)) begin
        buf_skid <= ram_dout;
      end
      buf_cnt <= land_idx + {1'b0, inflight};
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - randomized self-checking bench for ram_fifo_ctrl with a behavioural RAM
module tb_ram_fifo_ctrl;
  localparam int AW    = 6;
  localparam int DW    = 4;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_din;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_dout;
  logic [AW+1:0] count;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q[$];

  // Simple dual-port RAM: registered read address, unregistered read data
  logic [DW-1:0] ram_mem [DEPTH];
  logic [AW-1:0] ram_raddr_q;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_waddr] <= ram_din;
    ram_raddr_q <= ram_raddr;
  end
  assign ram_dout = ram_mem[ram_raddr_q];

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_din(ram_din),
    .ram_raddr(ram_raddr), .ram_dout(ram_dout), .count(count)
  );

  // One clock of stimulus from a negedge; the queue model tracks accepted and delivered words
  task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy,
                      output logic popped, output logic [DW-1:0] got,
                      output logic [DW-1:0] exp, output logic pushed);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    popped = out_valid && ordy;
    got    = out_data;
    exp    = 'x;
    if (popped && q.size() > 0) exp = q.pop_front();
    pushed = iv && in_ready;
    if (pushed) q.push_back(id);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    q.delete();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %0h want 0", out_data); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got %0b want 0", ram_we); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_latency();
    logic p, pu; logic [DW-1:0] g, e;
    int rise = -1;
    do_reset();
    step(1'b1, 4'h5, 1'b0, p, g, e, pu);
    for (int k = 1; k <= 8; k++) begin
      if (out_valid && rise < 0) rise = k;
      step(1'b0, 4'h0, 1'b0, p, g, e, pu);
    end
    checks++; if (rise !== 3) begin errors++; $display("FAIL latency_rise got %0d want 3", rise); end
    checks++; if (out_data !== 4'h5) begin errors++; $display("FAIL latency_data got %0h want 5", out_data); end
    checks++; if (count !== 1) begin errors++; $display("FAIL latency_count got %0d want 1", count); end
    step(1'b0, 4'h0, 1'b1, p, g, e, pu);
    checks++; if (!p || g !== e) begin errors++; $display("FAIL latency_pop got %0h/%0b want %0h/1", g, p, e); end
  endtask

  task automatic test_fill();
    logic p, pu; logic [DW-1:0] g, e;
    int acc = 0;
    do_reset();
    for (int i = 0; i < 66; i++) begin
      step(1'b1, 4'(i), 1'b0, p, g, e, pu);
      if (pu) acc++;
    end
    checks++; if (acc !== 66) begin errors++; $display("FAIL fill_accepts got %0d want 66", acc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %0b want 0", in_ready); end
    checks++; if (count !== 66) begin errors++; $display("FAIL fill_count got %0d want 66", count); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'hC, 1'b0, p, g, e, pu);
      checks++; if (pu !== 1'b0) begin errors++; $display("FAIL full_no_push got %0b want 0", pu); end
    end
    checks++; if (count !== q.size()) begin errors++; $display("FAIL full_count got %0d want %0d", count, q.size()); end
  endtask

  task automatic test_drain_from_full();
    logic p, pu; logic [DW-1:0] g, e;
    logic [DW-1:0] d = 4'(66);
    int pops = 0;
    int bad = 0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL drain_in_ready_before got %0b want 0", in_ready); end
    step(1'b1, d, 1'b1, p, g, e, pu);
    if (pu) d++;
    if (p) pops++;
    checks++; if (!p || g !== e) begin errors++; $display("FAIL drain_first_pop got %0h want %0h", g, e); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_in_ready_after got %0b want 1", in_ready); end
    for (int i = 0; i < 100; i++) begin
      step(1'b1, d, 1'b1, p, g, e, pu);
      if (pu) d++;
      if (p) pops++;
      if (p && g !== e) bad++;
    end
    checks++; if (pops !== 101) begin errors++; $display("FAIL drain_rate got %0d pops want 101", pops); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL drain_order got %0d bad words want 0", bad); end
    for (int i = 0; i < 200 && (q.size() > 0 || out_valid); i++) begin
      step(1'b0, 4'h0, 1'b1, p, g, e, pu);
      if (p && g !== e) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL drain_tail got %0d bad words want 0", bad); end
    checks++; if (count !== 0 || out_valid !== 1'b0 || q.size() != 0) begin
      errors++; $display("FAIL drain_empty got count %0d valid %0b want 0 0", count, out_valid);
    end
  endtask

  task automatic test_random();
    logic p, pu; logic [DW-1:0] g, e;
    int sent = 0, recv = 0, bad_data = 0, bad_cnt = 0, bad_rdy = 0;
    do_reset();
    for (int cyc = 0; cyc < 5000 && (sent < 200 || q.size() > 0); cyc++) begin
      if (count !== q.size()) bad_cnt++;
      if (q.size() < DEPTH && in_ready !== 1'b1) bad_rdy++;
      step((sent < 200) && ($urandom_range(0, 3) != 0), 4'($urandom), ($urandom_range(0, 2) != 0), p, g, e, pu);
      if (pu) sent++;
      if (p) begin
        recv++;
        if (g !== e) bad_data++;
      end
    end
    checks++; if (sent !== 200) begin errors++; $display("FAIL random_sent got %0d want 200", sent); end
    checks++; if (recv !== 200) begin errors++; $display("FAIL random_recv got %0d want 200", recv); end
    checks++; if (bad_data !== 0) begin errors++; $display("FAIL random_order got %0d bad words want 0", bad_data); end
    checks++; if (bad_cnt !== 0) begin errors++; $display("FAIL random_count got %0d bad cycles want 0", bad_cnt); end
    checks++; if (bad_rdy !== 0) begin errors++; $display("FAIL random_in_ready got %0d bad cycles want 0", bad_rdy); end
  endtask

  task automatic test_reset_mid();
    logic p, pu; logic [DW-1:0] g, e;
    int waited = 0;
    do_reset();
    for (int i = 0; i < 11; i++) step(1'b1, 4'(i + 3), 1'b0, p, g, e, pu);
    step(1'b0, 4'h0, 1'b1, p, g, e, pu);
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %0b want 0", out_valid); end
    checks++; if (count !== 0) begin errors++; $display("FAIL midreset_count got %0d want 0", count); end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, 4'hA, 1'b0, p, g, e, pu);
    while (!out_valid && waited < 10) begin
      step(1'b0, 4'h0, 1'b0, p, g, e, pu);
      waited++;
    end
    checks++; if (out_valid !== 1'b1 || out_data !== 4'hA) begin
      errors++; $display("FAIL midreset_first got %0h valid %0b want a 1", out_data, out_valid);
    end
    checks++; if (count !== 1) begin errors++; $display("FAIL midreset_held got %0d want 1", count); end
  endtask

  task automatic test_single_pop();
    logic p, pu; logic [DW-1:0] g, e;
    logic [DW-1:0] w = 4'($urandom);
    int waited = 0;
    int stale = 0;
    do_reset();
    step(1'b1, w, 1'b0, p, g, e, pu);
    while (!out_valid && waited < 10) begin
      step(1'b0, 4'h0, 1'b0, p, g, e, pu);
      waited++;
    end
    step(1'b0, 4'h0, 1'b1, p, g, e, pu);
    checks++; if (!p || g !== w) begin errors++; $display("FAIL single_pop got %0h/%0b want %0h/1", g, p, w); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_after_valid got %0b want 0", out_valid); end
    checks++; if (count !== 0) begin errors++; $display("FAIL single_after_count got %0d want 0", count); end
    for (int i = 0; i < 6; i++) begin
      if (out_valid !== 1'b0 || count !== 0) stale++;
      step(1'b0, 4'h0, 1'b1, p, g, e, pu);
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL single_stale got %0d cycles want 0", stale); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill();
    test_drain_from_full();
    test_random();
    test_reset_mid();
    test_single_pop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sequences the team's simple dual-port block RAM (registered read address, unregistered read data, write-enable on clock edge) into a ready/valid stream buffer.
- Owns write/read pointers, occupancy and a 2-entry show-ahead output buffer that hides the RAM's one-cycle read latency and sustains one word per clock.
- The RAM is instantiated outside this block and wired through the ram_* ports.

Parameters:
- ADDR_WIDTH, 6, RAM address width; RAM depth DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 4, word width.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  controller can accept a word.
- in_data  input  DATA_WIDTH  write word.
- out_valid  output  1  out_data holds the oldest word.
- out_ready  input  1  consumer takes the word.
- out_data  output  DATA_WIDTH  head word.
- ram_we  output  1  to RAM we.
- ram_waddr  output  ADDR_WIDTH  to RAM waddr.
- ram_din  output  DATA_WIDTH  to RAM din.
- ram_raddr  output  ADDR_WIDTH  to RAM raddr.
- ram_dout  input  DATA_WIDTH  from RAM dout; valid the cycle after ram_raddr was presented.
- count  output  ADDR_WIDTH+2  total words held: mem_cnt + inflight + buf_cnt.

Behaviour:
- State:
  - wptr, rptr: ADDR_WIDTH, wrap modulo DEPTH.
  - mem_cnt: 0..DEPTH; words in RAM not yet fetched.
  - inflight: 1 bit; a fetch is outstanding.
  - buf: 2 entries (head, skid), buf_cnt 0..2.
- Reset, asynchronous on rst_n low:
  - wptr = rptr = mem_cnt = inflight = buf_cnt = 0.
  - Outputs: out_valid = 0, count = 0, ram_we = 0, in_ready = 1 once rst_n is high.
  - out_data = 0.
  - RAM contents are not cleared; stale words must never reach out_data.
- Write:
  - in_ready = (mem_cnt < DEPTH).
  - push = in_valid & in_ready.
  - Combinationally: ram_we = push, ram_waddr = wptr, ram_din = in_data.
  - On the edge: wptr++, mem_cnt++ (net of fetch).
- Fetch:
  - ram_raddr = rptr at all times.
  - pop = out_valid & out_ready.
  - fetch = (mem_cnt > 0) & (buf_cnt + inflight - pop < 2).
  - On the edge: rptr++, mem_cnt--, inflight <= 1; otherwise inflight <= 0.
  - At most one fetch issues per cycle.
- Land: when inflight = 1, ram_dout is written into the next free buffer entry in that cycle, after the head shifts on pop.
- Output:
  - out_valid = (buf_cnt > 0); out_data = head entry, registered.
  - On pop, skid moves to head.
- Latency:
  - Push in cycle 0 with FIFO empty: mem_cnt = 1 in cycle 1, fetch in cycle 1, land in cycle 2, out_valid = 1 in cycle 3.
  - Steady state with out_ready held high: 1 word/cycle.
- Simultaneous events:
  - Push + fetch in the same cycle: mem_cnt unchanged.
  - Push into an empty RAM can never be fetched in the same cycle, because mem_cnt counts only committed words. This guarantees the RAM write lands before its address is registered.
- Full:
  - mem_cnt = DEPTH → in_ready = 0; total capacity is DEPTH + 2.
  - Push while a fetch frees a slot is allowed only in the following cycle; in_ready has no combinational path from out_ready.
- Empty: pop with buf_cnt = 0 is impossible (out_valid = 0); mem_cnt never underflows.
- Wrap: pointers roll from DEPTH-1 to 0 with no gap and no reorder.
- Ordering: strict FIFO; no word is lost or duplicated.
- Reset mid-operation: all state returns to the reset values immediately. Any in-flight ram_dout is discarded. The first word after reset is the first word pushed after reset.

Test Plan:
- Reset, then push 0x5 once with out_ready = 0 → out_valid rises exactly 3 cycles after the push; out_data = 0x5; count = 1.
- out_ready = 0; push 66 words 0x0..0xF repeating (ADDR_WIDTH = 6) → in_ready drops after the 66th accept (mem_cnt = 64, buf_cnt = 2); count = 66.
- From full, hold out_ready = 1 while pushing continuously → out_data sequence is unbroken, 1 word/cycle after refill; in_ready reasserts one cycle after the first fetch.
- Stream 200 words with random in_valid/out_ready → output order matches input, no drops or duplicates; pointers wrap at least 3 times.
- Assert rst_n low while 10 words are held and a fetch is inflight → out_valid = 0, count = 0 immediately. Push 0xA after release → first out_data = 0xA.
- Single push, then out_ready pulsed the cycle out_valid rises → out_valid returns to 0 the next cycle; count = 0; no stale RAM data appears.
